credit_stream_arbiter: RTL and testbench

CREDIT_STREAM_ARBITER -- requirements
Module: credit_stream_arbiter

---
 rtl/flow_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/credit_stream_arbiter.sv | 123 ++++++++++++
 tb/tb_credit_stream_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared definitions for the credit-based stream flow blocks.
// Holds the controller state encoding and the default credit sizing.
package flow_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } flow_state_e;

    localparam int FLOW_MAX_CREDITS  = 16;
    localparam int FLOW_CREDIT_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from the index after last_i,
// wrapping around, and returns a one-hot grant plus a valid flag.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IDX_W'((int'(last_i) + off) % N);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/credit_stream_arbiter.sv
// Packet-locked round-robin stream arbiter gated by a downstream credit pool.
//   state     | meaning
//   ST_IDLE   | no grant held; pick a requester when any source is valid
//   ST_LOCKED | forwarding the granted source until its tlast beat transfers
module credit_stream_arbiter
    import flow_pkg::*;
#(
    parameter  int NUM_SRC      = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int CREDIT_WIDTH = FLOW_CREDIT_WIDTH,
    parameter  int MAX_CREDITS  = FLOW_MAX_CREDITS,
    localparam int IDX_W        = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [IDX_W-1:0]              m_axis_tid,
    input  logic                          m_axis_tready,
    input  logic                          i_credit_return,
    input  logic [CREDIT_WIDTH-1:0]       i_credit_return_cnt,
    output logic [CREDIT_WIDTH-1:0]       o_credits,
    output logic [NUM_SRC-1:0]            o_grant,
    output logic                          o_busy
);

    localparam logic [CREDIT_WIDTH:0]   MAX_EXT = (CREDIT_WIDTH+1)'(MAX_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] MAX_CR  = CREDIT_WIDTH'(MAX_CREDITS);

    flow_state_e             state_q, state_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic [CREDIT_WIDTH:0]   cred_sum;
    logic [NUM_SRC-1:0]      rr_grant;
    logic                    rr_valid;
    logic [IDX_W-1:0]        rr_idx;
    logic                    have_credit;
    logic                    beat;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req_i   (s_axis_tvalid),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .valid_o (rr_valid)
    );

    always_comb begin
        rr_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rr_grant[i]) rr_idx = IDX_W'(i);
        end
    end

    assign have_credit = (credits_q != '0);

    always_comb begin
        state_d       = state_q;
        gidx_d        = gidx_q;
        last_d        = last_q;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        o_grant       = '0;
        o_busy        = 1'b0;
        m_axis_tid    = gidx_q;
        m_axis_tlast  = s_axis_tlast[gidx_q];
        m_axis_tdata  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gidx_q == IDX_W'(i)) m_axis_tdata = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    gidx_d  = rr_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                o_busy                = 1'b1;
                o_grant[gidx_q]       = 1'b1;
                m_axis_tvalid         = s_axis_tvalid[gidx_q] && have_credit;
                s_axis_tready[gidx_q] = m_axis_tready && have_credit;
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_d = ST_IDLE;
                    last_d  = gidx_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign beat = m_axis_tvalid && m_axis_tready;

    // Extra bit keeps credits+return from wrapping before the ceiling compare.
    always_comb begin
        cred_sum = {1'b0, credits_q}
                 + (i_credit_return ? {1'b0, i_credit_return_cnt} : '0)
                 - {{CREDIT_WIDTH{1'b0}}, beat};
        credits_d = (cred_sum > MAX_EXT) ? MAX_CR : cred_sum[CREDIT_WIDTH-1:0];
    end

    assign o_credits = credits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gidx_q    <= '0;
            last_q    <= IDX_W'(NUM_SRC - 1);
            credits_q <= MAX_CR;
        end else begin
            state_q   <= state_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            credits_q <= credits_d;
        end
    end

endmodule

// File: tb/tb_credit_stream_arbiter.sv
// Randomized and directed bench for credit_stream_arbiter, checked every
// cycle against a packet-level behavioural model.
module tb_credit_stream_arbiter;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int MAXC = 16;

    typedef struct packed {
        logic [1:0]    tid;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS*DW-1:0] s_tdata = '0;
    logic [NS-1:0]    s_tvalid = '0;
    logic [NS-1:0]    s_tlast = '0;
    logic [NS-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic [1:0]       m_tid;
    logic             m_tready = 1'b0;
    logic             ret = 1'b0;
    logic [CW-1:0]    ret_cnt = '0;
    logic [CW-1:0]    credits;
    logic [NS-1:0]    grant;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] src_data [NS];
    int rem  [NS];
    int pkts [NS];
    int plen [NS];
    int pvalid = 100;
    beat_t obs [$];

    bit m_locked;
    int m_g, m_last, m_cred;

    credit_stream_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .MAX_CREDITS(MAXC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid), .m_axis_tready(m_tready),
        .i_credit_return(ret), .i_credit_return_cnt(ret_cnt),
        .o_credits(credits), .o_grant(grant), .o_busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int rr_pick(int last, logic [NS-1:0] v);
        for (int k = 1; k <= NS; k++) if (v[(last + k) % NS]) return (last + k) % NS;
        return 0;
    endfunction

    function automatic bit model_beat();
        return m_locked && s_tvalid[m_g] && (m_cred > 0) && m_tready;
    endfunction

    function automatic int next_cred(int c, bit b, bit r, int n);
        int t = c - int'(b) + (r ? n : 0);
        return (t > MAXC) ? MAXC : t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked <= 1'b0;
            m_g      <= 0;
            m_last   <= NS - 1;
            m_cred   <= MAXC;
        end else begin
            m_cred <= next_cred(m_cred, model_beat(), ret, int'(ret_cnt));
            if (m_locked) begin
                if (model_beat() && s_tlast[m_g]) begin
                    m_locked <= 1'b0;
                    m_last   <= m_g;
                end
            end else if (|s_tvalid) begin
                m_locked <= 1'b1;
                m_g      <= rr_pick(m_last, s_tvalid);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("credits", credits, m_cred);
        if (!rst_n || !m_locked) begin
            chk("idle_tvalid", m_tvalid, 0);
            chk("idle_tready", s_tready, 0);
            chk("idle_grant", grant, 0);
            chk("idle_busy", busy, 0);
        end else begin
            chk("busy", busy, 1);
            chk("grant", grant, NS'(1) << m_g);
            chk("tid", m_tid, m_g);
            chk("tdata", m_tdata, s_tdata[m_g*DW +: DW]);
            chk("tlast", m_tlast, s_tlast[m_g]);
            chk("tvalid", m_tvalid, s_tvalid[m_g] && (m_cred > 0));
            chk("tready", s_tready, (m_tready && m_cred > 0) ? (NS'(1) << m_g) : NS'(0));
        end
        if (m_tvalid && m_tready) obs.push_back('{tid: m_tid, data: m_tdata, last: m_tlast});
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        logic [NS-1:0] acc;
        @(negedge clk);
        acc = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                rem[i]--;
                src_data[i] = $urandom;
            end
            if (rem[i] == 0 && pkts[i] > 0) begin
                rem[i] = (plen[i] != 0) ? plen[i] : int'($urandom_range(5, 1));
                pkts[i]--;
                src_data[i] = $urandom;
            end
            if (!(s_tvalid[i] && !acc[i]))
                s_tvalid[i] = (rem[i] > 0) && (int'($urandom_range(99)) < pvalid);
            s_tlast[i] = (rem[i] == 1);
            s_tdata[i*DW +: DW] = src_data[i];
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) begin
            rem[i] = 0; pkts[i] = 0; plen[i] = 0; src_data[i] = '0;
        end
        s_tvalid = '0; s_tlast = '0; s_tdata = '0;
        pvalid = 100;
        obs.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_tready = 1'b0; ret = 1'b0; ret_cnt = '0;
        clear_sources();
        cycle(); cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_obs(int n, int limit, string name);
        int k = 0;
        while (obs.size() < n && k < limit) begin cycle(); k++; end
        chk(name, obs.size(), n);
    endtask

    task automatic wait_busy(int limit, string name);
        int k = 0;
        while (!busy && k < limit) begin cycle(); k++; end
        chk(name, busy, 1);
    endtask

    initial begin
        logic [DW-1:0] held;
        for (int i = 0; i < NS; i++) begin rem[i] = 0; pkts[i] = 0; plen[i] = 0; src_data[i] = '0; end
        #1;
        // reset values
        do_reset();
        #2;
        chk("rst_credits", credits, 16);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);

        // fairness: everyone offers 2-beat packets, credit returned every cycle
        do_reset();
        for (int i = 0; i < NS; i++) begin plen[i] = 2; pkts[i] = 4; end
        m_tready = 1'b1; ret = 1'b1; ret_cnt = 8'd1;
        wait_obs(16, 200, "fair_beats");
        for (int k = 0; k < 16 && k < obs.size(); k++) begin
            chk("fair_tid", obs[k].tid, (k / 2) % 4);
            chk("fair_last", obs[k].last, k % 2);
        end

        // credit exhaustion on a 20-beat packet from source 1
        do_reset();
        plen[1] = 20; pkts[1] = 1; m_tready = 1'b1;
        wait_obs(16, 60, "exh_16beats");
        repeat (3) cycle();
        #2;
        chk("exh_count", obs.size(), 16);
        chk("exh_credits", credits, 0);
        chk("exh_tvalid", m_tvalid, 0);
        chk("exh_busy", busy, 1);
        ret = 1'b1; ret_cnt = 8'd4;
        cycle();
        ret = 1'b0; ret_cnt = '0;
        wait_obs(20, 30, "exh_20beats");
        repeat (2) cycle();
        #2;
        chk("exh_end_credits", credits, 0);
        chk("exh_end_busy", busy, 0);
        chk("exh_end_count", obs.size(), 20);
        if (obs.size() == 20) chk("exh_end_last", obs[19].last, 1);

        // simultaneous consume and return, then saturation
        do_reset();
        plen[0] = 11; pkts[0] = 1; m_tready = 1'b1;
        wait_obs(11, 40, "sim_setup_beats");
        repeat (2) cycle();
        chk("sim_credits5", credits, 5);
        m_tready = 1'b0; plen[1] = 1; pkts[1] = 1;
        wait_busy(10, "sim_lock");
        m_tready = 1'b1; ret = 1'b1; ret_cnt = 8'd3;
        cycle();
        m_tready = 1'b0; ret = 1'b0; ret_cnt = '0;
        chk("sim_beat", obs.size(), 12);
        chk("sim_credits7", credits, 7);
        repeat (2) cycle();
        ret = 1'b1; ret_cnt = 8'd8;
        cycle();
        ret = 1'b0; ret_cnt = '0;
        chk("sat_credits15", credits, 15);
        ret = 1'b1; ret_cnt = 8'd10;
        cycle();
        ret = 1'b0; ret_cnt = '0;
        chk("sat_credits16", credits, 16);
        ret = 1'b1; ret_cnt = 8'd0;
        cycle();
        ret = 1'b0;
        chk("ret_zero", credits, 16);

        // backpressure mid-packet
        do_reset();
        plen[3] = 6; pkts[3] = 1; m_tready = 1'b1;
        wait_obs(2, 20, "bp_pre_beats");
        m_tready = 1'b0;
        held = src_data[3];
        for (int k = 0; k < 10; k++) begin
            cycle();
            #2;
            chk("bp_tdata", m_tdata, held);
            chk("bp_tid", m_tid, 3);
            chk("bp_tvalid", m_tvalid, 1);
            chk("bp_credits", credits, 14);
        end
        m_tready = 1'b1;
        wait_obs(6, 20, "bp_all_beats");
        repeat (2) cycle();
        chk("bp_end_credits", credits, 10);
        if (obs.size() >= 3) chk("bp_no_loss", obs[2].data, held);

        // reset mid-packet, then source 0 wins first
        do_reset();
        plen[2] = 8; pkts[2] = 1; m_tready = 1'b1;
        wait_obs(2, 20, "rmp_pre_beats");
        rst_n = 1'b0;
        #2;
        chk("rmp_credits", credits, 16);
        chk("rmp_busy", busy, 0);
        chk("rmp_grant", grant, 0);
        chk("rmp_tvalid", m_tvalid, 0);
        chk("rmp_tready", s_tready, 0);
        cycle();
        clear_sources();
        for (int i = 0; i < NS; i++) begin plen[i] = 2; pkts[i] = 1; end
        cycle();
        rst_n = 1'b1;
        wait_obs(8, 60, "rmp_post_beats");
        for (int k = 0; k < 8 && k < obs.size(); k++) chk("rmp_order", obs[k].tid, k / 2);

        // randomized traffic with drops, backpressure and sparse returns
        do_reset();
        pvalid = 60;
        for (int i = 0; i < NS; i++) begin plen[i] = 0; pkts[i] = 1000; end
        for (int c = 0; c < 3000; c++) begin
            m_tready = ($urandom_range(3) != 0);
            ret      = ($urandom_range(3) == 0);
            ret_cnt  = CW'($urandom_range(3));
            if ($urandom_range(99) == 0) ret_cnt = CW'($urandom_range(20));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
